// File: rtl/mips_ctrl_pkg.sv
// Shared encodings for the multi-cycle MIPS control unit:
// opcodes, functs, ALU codes, mux selects and FSM states.
package mips_ctrl_pkg;

   localparam logic [5:0] OP_RTYPE = 6'h00;
   localparam logic [5:0] OP_J     = 6'h02;
   localparam logic [5:0] OP_JAL   = 6'h03;
   localparam logic [5:0] OP_BEQ   = 6'h04;
   localparam logic [5:0] OP_ADDI  = 6'h08;
   localparam logic [5:0] OP_SLTI  = 6'h0A;
   localparam logic [5:0] OP_LW    = 6'h23;
   localparam logic [5:0] OP_SW    = 6'h2B;

   localparam logic [5:0] FN_JR  = 6'h08;
   localparam logic [5:0] FN_ADD = 6'h20;
   localparam logic [5:0] FN_SUB = 6'h22;
   localparam logic [5:0] FN_AND = 6'h24;
   localparam logic [5:0] FN_OR  = 6'h25;
   localparam logic [5:0] FN_SLT = 6'h2A;

   localparam logic [2:0] ALU_AND = 3'b000;
   localparam logic [2:0] ALU_OR  = 3'b001;
   localparam logic [2:0] ALU_ADD = 3'b010;
   localparam logic [2:0] ALU_SUB = 3'b110;
   localparam logic [2:0] ALU_SLT = 3'b111;

   localparam logic [1:0] SRCB_B      = 2'b00;
   localparam logic [1:0] SRCB_4      = 2'b01;
   localparam logic [1:0] SRCB_IMM    = 2'b10;
   localparam logic [1:0] SRCB_IMM_SH = 2'b11;

   localparam logic [1:0] PCS_ALU    = 2'b00;
   localparam logic [1:0] PCS_ALUOUT = 2'b01;
   localparam logic [1:0] PCS_JUMP   = 2'b10;
   localparam logic [1:0] PCS_REGA   = 2'b11;

   localparam logic [1:0] RDST_RT = 2'b00;
   localparam logic [1:0] RDST_RD = 2'b01;
   localparam logic [1:0] RDST_RA = 2'b10;

   localparam logic [1:0] M2R_ALUOUT = 2'b00;
   localparam logic [1:0] M2R_MDR    = 2'b01;
   localparam logic [1:0] M2R_PC     = 2'b10;

   typedef enum logic [3:0] {
      S_RESET    = 4'd0,
      S_IF       = 4'd1,
      S_ID       = 4'd2,
      S_MEM_ADDR = 4'd3,
      S_MEM_RD   = 4'd4,
      S_MEM_WB   = 4'd5,
      S_MEM_WR   = 4'd6,
      S_R_EX     = 4'd7,
      S_R_WB     = 4'd8,
      S_I_EX     = 4'd9,
      S_I_WB     = 4'd10,
      S_BEQ      = 4'd11,
      S_J        = 4'd12,
      S_JAL      = 4'd13,
      S_JR       = 4'd14
   } state_t;

   typedef enum logic [2:0] {
      AC_NONE,
      AC_ADD,
      AC_SUB,
      AC_FUNCT,
      AC_IMM
   } alu_class_t;

   function automatic logic is_alu_funct(input logic [5:0] f);
      return (f == FN_ADD) || (f == FN_SUB) || (f == FN_AND) ||
             (f == FN_OR)  || (f == FN_SLT);
   endfunction

endpackage

// File: rtl/alu_op_decoder.sv
// Maps an ALU usage class plus opcode/funct to the 3-bit ALU select.
// Only the five legal ALU codes can ever come out.
module alu_op_decoder
   import mips_ctrl_pkg::*;
(
   input  alu_class_t cls_i,
   input  logic [5:0] opcode_i,
   input  logic [5:0] funct_i,
   output logic [2:0] alu_op_o
);

   always_comb begin
      alu_op_o = ALU_AND;
      unique case (cls_i)
         AC_ADD: alu_op_o = ALU_ADD;
         AC_SUB: alu_op_o = ALU_SUB;
         AC_IMM: alu_op_o = (opcode_i == OP_SLTI) ? ALU_SLT : ALU_ADD;
         AC_FUNCT: begin
            unique case (funct_i)
               FN_SUB:  alu_op_o = ALU_SUB;
               FN_AND:  alu_op_o = ALU_AND;
               FN_OR:   alu_op_o = ALU_OR;
               FN_SLT:  alu_op_o = ALU_SLT;
               default: alu_op_o = ALU_ADD;
            endcase
         end
         default: alu_op_o = ALU_AND;
      endcase
   end

endmodule

// File: rtl/mc_control_unit.sv
// Multi-cycle MIPS control FSM: fetch/decode/execute/mem/writeback,
// one instruction at a time, outputs decoded from the state register.
module mc_control_unit
   import mips_ctrl_pkg::*;
#(
   parameter bit RESET_TO_FETCH = 1'b1
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       start,
   input  logic [5:0] opcode,
   input  logic [5:0] funct,
   input  logic       zero,
   input  logic       mem_ready,
   output logic [2:0] alu_op,
   output logic       alu_srca,
   output logic [1:0] alu_srcb,
   output logic [1:0] pc_source,
   output logic       pc_en,
   output logic       iord,
   output logic       mem_read,
   output logic       mem_write,
   output logic       ir_write,
   output logic [1:0] reg_dst,
   output logic [1:0] mem_to_reg,
   output logic       reg_write,
   output logic       instr_done,
   output logic       illegal
);

   state_t     state_q, state_d;
   alu_class_t acls;

   alu_op_decoder u_aludec (
      .cls_i    (acls),
      .opcode_i (opcode),
      .funct_i  (funct),
      .alu_op_o (alu_op)
   );

   always_ff @(posedge clk or posedge rst) begin
      if (rst) state_q <= S_RESET;
      else     state_q <= state_d;
   end

   always_comb begin
      state_d    = state_q;
      acls       = AC_NONE;
      alu_srca   = 1'b0;
      alu_srcb   = SRCB_B;
      pc_source  = PCS_ALU;
      pc_en      = 1'b0;
      iord       = 1'b0;
      mem_read   = 1'b0;
      mem_write  = 1'b0;
      ir_write   = 1'b0;
      reg_dst    = RDST_RT;
      mem_to_reg = M2R_ALUOUT;
      reg_write  = 1'b0;
      instr_done = 1'b0;
      illegal    = 1'b0;
      unique case (state_q)
         S_RESET: begin
            if (RESET_TO_FETCH || start) state_d = S_IF;
         end
         S_IF: begin
            mem_read = 1'b1;
            alu_srcb = SRCB_4;
            acls     = AC_ADD;
            if (mem_ready) begin
               ir_write = 1'b1;
               pc_en    = 1'b1;
               state_d  = S_ID;
            end
         end
         S_ID: begin
            // Branch target is speculatively computed into ALUOut here
            alu_srcb = SRCB_IMM_SH;
            acls     = AC_ADD;
            unique case (opcode)
               OP_RTYPE: begin
                  if (funct == FN_JR)           state_d = S_JR;
                  else if (is_alu_funct(funct)) state_d = S_R_EX;
                  else begin
                     illegal    = 1'b1;
                     instr_done = 1'b1;
                     state_d    = S_IF;
                  end
               end
               OP_LW, OP_SW:     state_d = S_MEM_ADDR;
               OP_BEQ:           state_d = S_BEQ;
               OP_ADDI, OP_SLTI: state_d = S_I_EX;
               OP_J:             state_d = S_J;
               OP_JAL:           state_d = S_JAL;
               default: begin
                  illegal    = 1'b1;
                  instr_done = 1'b1;
                  state_d    = S_IF;
               end
            endcase
         end
         S_MEM_ADDR: begin
            alu_srca = 1'b1;
            alu_srcb = SRCB_IMM;
            acls     = AC_ADD;
            state_d  = (opcode == OP_LW) ? S_MEM_RD : S_MEM_WR;
         end
         S_MEM_RD: begin
            iord     = 1'b1;
            mem_read = 1'b1;
            if (mem_ready) state_d = S_MEM_WB;
         end
         S_MEM_WB: begin
            mem_to_reg = M2R_MDR;
            reg_write  = 1'b1;
            instr_done = 1'b1;
            state_d    = S_IF;
         end
         S_MEM_WR: begin
            iord      = 1'b1;
            mem_write = 1'b1;
            if (mem_ready) begin
               instr_done = 1'b1;
               state_d    = S_IF;
            end
         end
         S_R_EX: begin
            alu_srca = 1'b1;
            acls     = AC_FUNCT;
            state_d  = S_R_WB;
         end
         S_R_WB: begin
            reg_dst    = RDST_RD;
            reg_write  = 1'b1;
            instr_done = 1'b1;
            state_d    = S_IF;
         end
         S_I_EX: begin
            alu_srca = 1'b1;
            alu_srcb = SRCB_IMM;
            acls     = AC_IMM;
            state_d  = S_I_WB;
         end
         S_I_WB: begin
            reg_write  = 1'b1;
            instr_done = 1'b1;
            state_d    = S_IF;
         end
         S_BEQ: begin
            alu_srca   = 1'b1;
            acls       = AC_SUB;
            pc_source  = PCS_ALUOUT;
            pc_en      = zero;
            instr_done = 1'b1;
            state_d    = S_IF;
         end
         S_J: begin
            pc_source  = PCS_JUMP;
            pc_en      = 1'b1;
            instr_done = 1'b1;
            state_d    = S_IF;
         end
         S_JAL: begin
            // Link value is the PC+4 already latched during fetch
            reg_dst    = RDST_RA;
            mem_to_reg = M2R_PC;
            reg_write  = 1'b1;
            pc_source  = PCS_JUMP;
            pc_en      = 1'b1;
            instr_done = 1'b1;
            state_d    = S_IF;
         end
         S_JR: begin
            pc_source  = PCS_REGA;
            pc_en      = 1'b1;
            instr_done = 1'b1;
            state_d    = S_IF;
         end
         default: state_d = S_IF;
      endcase
   end

endmodule

// File: tb/tb_mc_control_unit.sv
// Scoreboard bench for mc_control_unit: per-cycle expected output
// vectors are queued by the driver and checked by a negedge monitor.
module tb_mc_control_unit;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       start = 1'b0;
   logic [5:0] opcode = '0;
   logic [5:0] funct = '0;
   logic       zero = 1'b0;
   logic       mem_ready = 1'b0;
   logic [2:0] alu_op;
   logic       alu_srca;
   logic [1:0] alu_srcb;
   logic [1:0] pc_source;
   logic       pc_en;
   logic       iord;
   logic       mem_read;
   logic       mem_write;
   logic       ir_write;
   logic [1:0] reg_dst;
   logic [1:0] mem_to_reg;
   logic       reg_write;
   logic       instr_done;
   logic       illegal;

   mc_control_unit #(.RESET_TO_FETCH(1'b1)) dut (
      .clk        (clk),
      .rst        (rst),
      .start      (start),
      .opcode     (opcode),
      .funct      (funct),
      .zero       (zero),
      .mem_ready  (mem_ready),
      .alu_op     (alu_op),
      .alu_srca   (alu_srca),
      .alu_srcb   (alu_srcb),
      .pc_source  (pc_source),
      .pc_en      (pc_en),
      .iord       (iord),
      .mem_read   (mem_read),
      .mem_write  (mem_write),
      .ir_write   (ir_write),
      .reg_dst    (reg_dst),
      .mem_to_reg (mem_to_reg),
      .reg_write  (reg_write),
      .instr_done (instr_done),
      .illegal    (illegal)
   );

   always #5 clk = ~clk;

   typedef enum {K_R, K_I, K_LW, K_SW, K_BEQ, K_J, K_JAL, K_JR, K_ILL} kind_t;

   typedef struct {
      logic [19:0] v;
      string       nm;
      int          idx;
   } exp_t;

   exp_t exp_q[$];
   exp_t cur;
   int   n_chk = 0;
   int   n_fail = 0;

   logic [19:0] act;
   assign act = {alu_op, alu_srca, alu_srcb, pc_source, pc_en, iord,
                 mem_read, mem_write, ir_write, reg_dst, mem_to_reg,
                 reg_write, instr_done, illegal};

   function automatic logic [19:0] ov(
      input logic [2:0] aop, input logic sa, input logic [1:0] sb,
      input logic [1:0] pcs, input logic pce, input logic io,
      input logic mr, input logic mw, input logic irw,
      input logic [1:0] rd, input logic [1:0] m2r,
      input logic rw, input logic dn, input logic il);
      return {aop, sa, sb, pcs, pce, io, mr, mw, irw, rd, m2r, rw, dn, il};
   endfunction

   task automatic chk(input string nm, input logic [19:0] got,
                      input logic [19:0] want);
      n_chk++;
      if (got !== want) begin
         n_fail++;
         $display("FAIL %s: got %b want %b", nm, got, want);
      end
   endtask

   always @(negedge clk) begin
      if (exp_q.size() != 0) begin
         cur = exp_q.pop_front();
         chk($sformatf("%s[%0d]", cur.nm, cur.idx), act, cur.v);
      end
      if (!rst) begin
         chk("rd_wr_excl", 20'(mem_read & mem_write), 20'd0);
         chk("rw_wr_excl", 20'(reg_write & mem_write), 20'd0);
      end
   end

   // Per-state expected vectors, written out from the output table
   function automatic logic [19:0] v_if(input logic rdy);
      return ov(3'b010, 0, 2'b01, 2'b00, rdy, 0, 1, 0, rdy, 2'b00, 2'b00, 0, 0, 0);
   endfunction

   task automatic push(input string nm, input logic [19:0] v[$]);
      exp_t e;
      foreach (v[i]) begin
         e.v = v[i]; e.nm = nm; e.idx = i;
         exp_q.push_back(e);
      end
   endtask

   task automatic issue(input string nm, input logic [5:0] op,
                        input logic [5:0] fn, input kind_t k,
                        input logic [2:0] aop, input logic z,
                        input int ifw, input int mw);
      logic [19:0] ev[$];
      logic        rdy[$];
      for (int i = 0; i < ifw; i++) begin
         ev.push_back(v_if(0)); rdy.push_back(0);
      end
      ev.push_back(v_if(1)); rdy.push_back(1);
      if (k == K_ILL)
         ev.push_back(ov(3'b010, 0, 2'b11, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1));
      else
         ev.push_back(ov(3'b010, 0, 2'b11, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
      rdy.push_back(0);
      case (k)
         K_R: begin
            ev.push_back(ov(aop, 1, 2'b00, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
            ev.push_back(ov(0, 0, 0, 0, 0, 0, 0, 0, 0, 2'b01, 2'b00, 1, 1, 0));
            rdy.push_back(0); rdy.push_back(0);
         end
         K_I: begin
            ev.push_back(ov(aop, 1, 2'b10, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
            ev.push_back(ov(0, 0, 0, 0, 0, 0, 0, 0, 0, 2'b00, 2'b00, 1, 1, 0));
            rdy.push_back(0); rdy.push_back(0);
         end
         K_LW: begin
            ev.push_back(ov(3'b010, 1, 2'b10, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
            rdy.push_back(0);
            for (int i = 0; i <= mw; i++) begin
               ev.push_back(ov(0, 0, 0, 0, 0, 1, 1, 0, 0, 0, 0, 0, 0, 0));
               rdy.push_back(i == mw);
            end
            ev.push_back(ov(0, 0, 0, 0, 0, 0, 0, 0, 0, 2'b00, 2'b01, 1, 1, 0));
            rdy.push_back(0);
         end
         K_SW: begin
            ev.push_back(ov(3'b010, 1, 2'b10, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
            rdy.push_back(0);
            for (int i = 0; i <= mw; i++) begin
               ev.push_back(ov(0, 0, 0, 0, 0, 1, 0, 1, 0, 0, 0, 0, i == mw, 0));
               rdy.push_back(i == mw);
            end
         end
         K_BEQ: begin
            ev.push_back(ov(3'b110, 1, 2'b00, 2'b01, z, 0, 0, 0, 0, 0, 0, 0, 1, 0));
            rdy.push_back(0);
         end
         K_J: begin
            ev.push_back(ov(0, 0, 0, 2'b10, 1, 0, 0, 0, 0, 0, 0, 0, 1, 0));
            rdy.push_back(0);
         end
         K_JAL: begin
            ev.push_back(ov(0, 0, 0, 2'b10, 1, 0, 0, 0, 0, 2'b10, 2'b10, 1, 1, 0));
            rdy.push_back(0);
         end
         K_JR: begin
            ev.push_back(ov(0, 0, 0, 2'b11, 1, 0, 0, 0, 0, 0, 0, 0, 1, 0));
            rdy.push_back(0);
         end
         default: ;
      endcase
      opcode = op;
      funct  = fn;
      zero   = z;
      push(nm, ev);
      foreach (rdy[i]) begin
         mem_ready = rdy[i];
         @(posedge clk); #1;
      end
      mem_ready = 1'b0;
   endtask

   task automatic reset_mid_sw();
      logic [19:0] ev[$];
      ev.push_back(v_if(1));
      ev.push_back(ov(3'b010, 0, 2'b11, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
      ev.push_back(ov(3'b010, 1, 2'b10, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
      ev.push_back(ov(0, 0, 0, 0, 0, 1, 0, 1, 0, 0, 0, 0, 0, 0));
      opcode = 6'h2B;
      funct  = 6'h00;
      push("sw_rst", ev);
      mem_ready = 1'b1;
      @(posedge clk); #1;
      mem_ready = 1'b0;
      repeat (3) begin
         @(posedge clk); #1;
      end
      ev.delete();
      ev.push_back(20'd0);
      ev.push_back(20'd0);
      push("rst_zero", ev);
      #1;
      chk("mw_before_rst", 20'(mem_write), 20'd1);
      rst = 1'b1;
      #1;
      chk("mw_async_drop", 20'(mem_write), 20'd0);
      @(posedge clk); #1;
      rst = 1'b0;
      @(posedge clk); #1;
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: sim time expired, queue %0d", exp_q.size());
      $fatal(1);
   end

   initial begin
      logic [19:0] z0[$];
      repeat (2) @(posedge clk);
      #1;
      rst = 1'b0;
      z0.push_back(20'd0);
      push("reset_state", z0);
      @(posedge clk); #1;

      issue("add",    6'h00, 6'h20, K_R,   3'b010, 0, 0, 0);
      issue("lw_w2",  6'h23, 6'h00, K_LW,  3'b010, 0, 0, 2);
      issue("beq_z1", 6'h04, 6'h00, K_BEQ, 3'b110, 1, 0, 0);
      issue("beq_z0", 6'h04, 6'h00, K_BEQ, 3'b110, 0, 0, 0);
      issue("slt",    6'h00, 6'h2A, K_R,   3'b111, 0, 0, 0);
      issue("slti",   6'h0A, 6'h2A, K_I,   3'b111, 0, 0, 0);
      issue("addi",   6'h08, 6'h24, K_I,   3'b010, 0, 0, 0);
      issue("sub",    6'h00, 6'h22, K_R,   3'b110, 0, 1, 0);
      issue("and",    6'h00, 6'h24, K_R,   3'b000, 0, 0, 0);
      issue("or",     6'h00, 6'h25, K_R,   3'b001, 0, 0, 0);
      issue("sw",     6'h2B, 6'h00, K_SW,  3'b010, 0, 0, 0);
      issue("sw_w1",  6'h2B, 6'h00, K_SW,  3'b010, 0, 0, 1);
      issue("lw",     6'h23, 6'h00, K_LW,  3'b010, 0, 0, 0);
      issue("j",      6'h02, 6'h00, K_J,   3'b010, 0, 0, 0);
      issue("jal",    6'h03, 6'h00, K_JAL, 3'b010, 0, 0, 0);
      issue("jr",     6'h00, 6'h08, K_JR,  3'b010, 0, 0, 0);
      issue("ill_op", 6'h3F, 6'h20, K_ILL, 3'b010, 0, 0, 0);
      issue("ill_fn", 6'h00, 6'h01, K_ILL, 3'b010, 0, 0, 0);
      reset_mid_sw();
      issue("add_post", 6'h00, 6'h20, K_R, 3'b010, 0, 0, 0);

      @(posedge clk); #1;
      chk("queue_drained", 20'(exp_q.size()), 20'd0);
      $display("End of test - %0d assertions evaluated, %0d failures",
               n_chk, n_fail);
      $finish;
   end

endmodule
